// File: rtl/tcm_dma_pkg.sv
// rtl/tcm_dma_pkg.sv - shared state encoding and mode constants for tcm_dma
package tcm_dma_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_RD   = 3'd1;
  localparam state_t ST_WAIT = 3'd2;
  localparam state_t ST_WR   = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/tcm_dma_if.sv
// rtl/tcm_dma_if.sv - scratchpad memory port between tcm_dma and its target RAM
interface tcm_dma_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRW      = 10
);

  logic                    mem_en_o;
  logic                    mem_we_o;
  logic [DATA_WIDTH/8-1:0] mem_be_o;
  logic [ADDRW-1:0]        mem_addr_o;
  logic [DATA_WIDTH-1:0]   mem_data_o;
  logic [DATA_WIDTH-1:0]   mem_data_i;
  logic                    mem_ready_i;

  // DMA engine side
  modport master (
    output mem_en_o,
    output mem_we_o,
    output mem_be_o,
    output mem_addr_o,
    output mem_data_o,
    input  mem_data_i,
    input  mem_ready_i
  );

  // memory side
  modport slave (
    input  mem_en_o,
    input  mem_we_o,
    input  mem_be_o,
    input  mem_addr_o,
    input  mem_data_o,
    output mem_data_i,
    output mem_ready_i
  );

endinterface

// File: rtl/tcm_dma.sv
// rtl/tcm_dma.sv - copy/fill DMA engine for a single-port tightly coupled scratchpad
module tcm_dma
  import tcm_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_ENTRIES  = 1024,
  parameter int ADDRW      = $clog2(N_ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [ADDRW-1:0]      src_addr_i,
  input  logic [ADDRW-1:0]      dst_addr_i,
  input  logic [ADDRW:0]        len_i,
  input  logic [DATA_WIDTH-1:0] fill_data_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o,
  output logic [ADDRW:0]        words_o,
  tcm_dma_if.master             mem
);

  localparam int NBYTES = DATA_WIDTH / 8;

  state_t                state;
  logic                  mode_q;
  logic [ADDRW-1:0]      src_q;
  logic [ADDRW-1:0]      dst_q;
  logic [ADDRW:0]        len_q;
  logic [ADDRW:0]        words_q;
  logic [DATA_WIDTH-1:0] fill_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  aborted_q;

  logic [ADDRW:0]        words_nxt;

  logic                  en;
  logic                  we;
  logic [NBYTES-1:0]     be;
  logic [ADDRW-1:0]      addr;
  logic [DATA_WIDTH-1:0] wdata;

  // Word address increment that wraps at N_ENTRIES even when it is not a power of two.
  function automatic logic [ADDRW-1:0] addr_inc(input logic [ADDRW-1:0] a);
    logic [ADDRW-1:0] r;
    if (a == ADDRW'(N_ENTRIES - 1)) begin
      r = '0;
    end else begin
      r = a + 1'b1;
    end
    return r;
  endfunction

  assign words_nxt = words_q + 1'b1;

  // Transfer sequencing: latch the request, walk RD/WAIT/WR per word, finish in DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_COPY;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      words_q   <= '0;
      fill_q    <= '0;
      rdata_q   <= '0;
      aborted_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            mode_q    <= mode_i;
            src_q     <= src_addr_i;
            dst_q     <= dst_addr_i;
            len_q     <= len_i;
            fill_q    <= fill_data_i;
            words_q   <= '0;
            aborted_q <= 1'b0;
            if (len_i == '0) begin
              state <= ST_DONE;
            end else if (mode_i == MODE_FILL) begin
              state <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (abort_i) begin
            aborted_q <= 1'b1;
            state     <= ST_DONE;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (abort_i) begin
            aborted_q <= 1'b1;
            state     <= ST_DONE;
          end else if (mem.mem_ready_i) begin
            rdata_q <= mem.mem_data_i;
            state   <= ST_WR;
          end
        end
        ST_WR: begin
          // An abort on any write, including the last one, suppresses that write.
          if (abort_i) begin
            aborted_q <= 1'b1;
            state     <= ST_DONE;
          end else begin
            words_q <= words_nxt;
            src_q   <= addr_inc(src_q);
            dst_q   <= addr_inc(dst_q);
            if (words_nxt == len_q) begin
              state <= ST_DONE;
            end else if (mode_q == MODE_FILL) begin
              state <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory port decode; abort gates the enable combinationally so no access leaks that cycle.
  always_comb begin
    en    = 1'b0;
    we    = 1'b0;
    be    = '0;
    addr  = '0;
    wdata = '0;
    case (state)
      ST_RD: begin
        en   = !abort_i;
        addr = src_q;
      end
      ST_WR: begin
        en    = !abort_i;
        we    = !abort_i;
        be    = '1;
        addr  = dst_q;
        wdata = (mode_q == MODE_FILL) ? fill_q : rdata_q;
      end
      default: begin
      end
    endcase
  end

  assign mem.mem_en_o   = en;
  assign mem.mem_we_o   = we;
  assign mem.mem_be_o   = be;
  assign mem.mem_addr_o = addr;
  assign mem.mem_data_o = wdata;

  assign busy_o    = (state != ST_IDLE);
  assign done_o    = (state == ST_DONE);
  assign aborted_o = aborted_q;
  assign words_o   = words_q;

endmodule

// File: tb/tb_tcm_dma.sv
// tb/tb_tcm_dma.sv - self-checking bench for tcm_dma with a behavioural scratchpad model
module tb_tcm_dma;
  import tcm_dma_pkg::*;

  localparam int DW = 32;
  localparam int N  = 1024;
  localparam int AW = 10;
  localparam int LW = AW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [AW-1:0] src_a;
  logic [AW-1:0] dst_a;
  logic [LW-1:0] len;
  logic [DW-1:0] fill;
  logic          abort;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [LW-1:0] words;

  always #5 clk = ~clk;

  tcm_dma_if #(.DATA_WIDTH(DW), .ADDRW(AW)) mif ();

  tcm_dma #(.DATA_WIDTH(DW), .N_ENTRIES(N), .ADDRW(AW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .mode_i     (mode),
    .src_addr_i (src_a),
    .dst_addr_i (dst_a),
    .len_i      (len),
    .fill_data_i(fill),
    .abort_i    (abort),
    .busy_o     (busy),
    .done_o     (done),
    .aborted_o  (aborted),
    .words_o    (words),
    .mem        (mif)
  );

  logic [DW-1:0] mem     [N];
  logic [DW-1:0] ref_mem [N];
  logic [DW-1:0] rd_q;
  logic          pend;
  int            wait_left;
  int            stall_cfg;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  int            cyc = 0;
  int            wlog_addr[$];
  int            wlog_cyc[$];
  int            rlog[$];

  int nerr = 0;
  int nchk = 0;
  int cs, w0, r0;

  // free-running cycle counter used to time writes and completion
  always @(posedge clk) cyc <= cyc + 1;

  // scratchpad model: byte-enabled writes, reads answered after 1 + stall_cfg cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= 1'b0;
      wait_left <= 0;
    end else begin
      if (bd_we) mem[bd_addr] <= bd_data;
      if (mif.mem_en_o && mif.mem_we_o) begin
        for (int b = 0; b < DW / 8; b++)
          if (mif.mem_be_o[b]) mem[mif.mem_addr_o][b*8 +: 8] <= mif.mem_data_o[b*8 +: 8];
        wlog_addr.push_back(int'(mif.mem_addr_o));
        wlog_cyc.push_back(cyc);
      end
      if (mif.mem_en_o && !mif.mem_we_o) begin
        rd_q      <= mem[mif.mem_addr_o];
        pend      <= 1'b1;
        wait_left <= stall_cfg;
        rlog.push_back(int'(mif.mem_addr_o));
      end else if (pend) begin
        if (wait_left == 0) pend <= 1'b0;
        else wait_left <= wait_left - 1;
      end
    end
  end

  assign mif.mem_ready_i = pend && (wait_left == 0);
  assign mif.mem_data_i  = rd_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_addr = a[AW-1:0];
    bd_data = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic model_xfer(input logic md, input int s, input int d, input int n, input logic [DW-1:0] p);
    for (int i = 0; i < n; i++) begin
      if (md == MODE_FILL) ref_mem[(d + i) % N] = p;
      else ref_mem[(d + i) % N] = ref_mem[(s + i) % N];
    end
  endtask

  task automatic chk_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic start_xfer(input logic md, input int s, input int d, input int l,
                            input logic [DW-1:0] p, input int stl);
    @(negedge clk);
    stall_cfg = stl;
    start = 1'b1;
    mode  = md;
    src_a = s[AW-1:0];
    dst_a = d[AW-1:0];
    len   = l[LW-1:0];
    fill  = p;
    w0    = wlog_addr.size();
    r0    = rlog.size();
    @(posedge clk);
    #1;
    cs    = cyc;
    start = 1'b0;
    mode  = 1'($urandom);
    src_a = AW'($urandom);
    dst_a = AW'($urandom);
    len   = LW'($urandom);
    fill  = $urandom;
  endtask

  task automatic wait_done(input bit poke, output int lat, output logic ab, output int wds);
    int guard = 0;
    while (done !== 1'b1 && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("done_seen", done, 1);
    lat = cyc - cs + 1;
    ab  = aborted;
    wds = int'(words);
    if (poke) begin
      start = 1'b1;
      mode  = MODE_FILL;
      len   = LW'(1);
      dst_a = AW'($urandom);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  task automatic run_xfer(input string tag, input logic md, input int s, input int d, input int l,
                          input logic [DW-1:0] p, input int stl, input bit busy_poke, input bit done_poke);
    int lat, wds, exp_lat, bad;
    logic ab;
    start_xfer(md, s, d, l, p, stl);
    if (busy_poke && l > 0) begin
      @(negedge clk);
      start = 1'b1;
      mode  = ~md;
      len   = LW'(5);
      dst_a = AW'($urandom);
      @(posedge clk);
      #1 start = 1'b0;
    end
    wait_done(done_poke, lat, ab, wds);
    model_xfer(md, s, d, l, p);
    if (l == 0) exp_lat = 1;
    else if (md == MODE_FILL) exp_lat = l + 1;
    else exp_lat = l * (3 + stl) + 1;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_words"}, wds, l);
    chk({tag, "_aborted"}, ab, 0);
    chk({tag, "_writes"}, wlog_addr.size() - w0, l);
    chk({tag, "_reads"}, rlog.size() - r0, (md == MODE_FILL) ? 0 : l);
    bad = 0;
    for (int k = 0; k < l && (w0 + k) < wlog_addr.size(); k++) begin
      if (wlog_addr[w0 + k] != (d + k) % N) bad++;
      if (wlog_cyc[w0 + k] - wlog_cyc[w0] != k * ((md == MODE_FILL) ? 1 : (3 + stl))) bad++;
    end
    chk({tag, "_wr_order"}, bad, 0);
    chk_mem({tag, "_mem"});
  endtask

  task automatic abort_fill(input string tag, input int d, input int l, input int k, input logic [DW-1:0] p);
    start_xfer(MODE_FILL, 0, d, l, p, 0);
    repeat (k - 1) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    #1;
    chk({tag, "_en_gated"}, mif.mem_en_o, 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_aborted"}, aborted, 1);
    chk({tag, "_words"}, words, k - 1);
    model_xfer(MODE_FILL, 0, d, k - 1, p);
    chk({tag, "_writes"}, wlog_addr.size() - w0, k - 1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_aborted_held"}, aborted, 1);
    chk_mem({tag, "_mem"});
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = 1'b0; src_a = '0; dst_a = '0; len = '0; fill = '0;
    abort = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0; stall_cfg = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_words", words, 0);
    chk("rst_en", mif.mem_en_o, 0);
    chk("rst_we", mif.mem_we_o, 0);
    chk("rst_addr", mif.mem_addr_o, 0);
    chk("rst_data", mif.mem_data_o, 0);
    chk("rst_be", mif.mem_be_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < N; i++) bd_write(i, $urandom);

    run_xfer("fill_wrap", MODE_FILL, 0, 'h3FE, 4, 32'hA5A5A5A5, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bd_write('h10 + i, i + 1);
    run_xfer("copy8", MODE_COPY, 'h10, 'h100, 8, 0, 0, 1'b0, 1'b0);
    run_xfer("len0", MODE_COPY, 'h10, 'h200, 0, 0, 0, 1'b0, 1'b0);
    abort_fill("abort_wr3", 'h50, 10, 3, 32'hDEADBEEF);
    abort_fill("abort_last", 'h60, 3, 3, 32'h12345678);
    run_xfer("stall5", MODE_COPY, 'h10, 'h180, 4, 0, 5, 1'b0, 1'b0);
    run_xfer("overlap", MODE_COPY, 'h40, 'h42, 6, 0, 0, 1'b0, 1'b0);
    run_xfer("copy_wrap", MODE_COPY, 'h3FC, 'h3FE, 6, 0, 1, 1'b0, 1'b0);
    run_xfer("start_in_done", MODE_FILL, 0, 'h220, 2, 32'h0F0F0F0F, 0, 1'b0, 1'b1);
    run_xfer("start_busy", MODE_COPY, 'h100, 'h240, 5, 0, 0, 1'b1, 1'b0);
    run_xfer("fill_full", MODE_FILL, 0, 5, N, 32'hC3C3C3C3, 0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) bd_write((i * 17) % N, $urandom);

    start_xfer(MODE_COPY, 'h20, 'h300, 4, 0, 0);
    @(posedge clk);
    #1;
    chk("rstwait_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rstwait_en", mif.mem_en_o, 0);
    chk("rstwait_we", mif.mem_we_o, 0);
    chk("rstwait_bus", {mif.mem_be_o, mif.mem_addr_o, mif.mem_data_o}, 0);
    chk("rstwait_busy0", busy, 0);
    chk("rstwait_words", words, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rstwait_no_done", done, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    chk("rstwait_writes", wlog_addr.size() - w0, 0);
    chk_mem("rstwait_mem");

    for (int t = 0; t < 12; t++) begin
      int l;
      l = $urandom_range(0, 20);
      run_xfer($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), $urandom_range(0, N - 1),
               $urandom_range(0, N - 1), l, $urandom, $urandom_range(0, 2),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
